// File: rtl/pulse_seq_pkg.sv
// Shared definitions for the pulse symbol sequencer: FSM state encoding,
// default parameter widths and derived-width helpers.
package pulse_seq_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } seq_state_e;

  localparam int unsigned DEF_NUM_WORDS = 8;
  localparam int unsigned DEF_SYM_BITS  = 2;
  localparam int unsigned DEF_DUR_W     = 8;
  localparam int unsigned DEF_PRESC_W   = 4;
  localparam int unsigned DEF_CARRIER_W = 16;
  localparam int unsigned SYMS_PER_WORD = 32 / DEF_SYM_BITS;

  // Width of a symbol index covering the whole program memory.
  function automatic int unsigned pcw_of(input int unsigned num_words,
                                         input int unsigned sym_bits);
    return $clog2(num_words * 32 / sym_bits);
  endfunction

  // Word address width; a single-word memory still gets a 1-bit address.
  function automatic int unsigned addr_w_of(input int unsigned num_words);
    return (num_words > 1) ? $clog2(num_words) : 1;
  endfunction

endpackage

// File: rtl/pulse_symbol_sequencer_if.sv
// Bus bundle between the register wrapper (master) and the sequencer (slave).
//   mem_wr_en/addr/data : program memory write port
//   start/stop          : launch (rising edge) and abort controls
//   busy/done/loop_irq  : run status and one-cycle event pulses
//   cur_idx             : index of the symbol currently playing
interface pulse_symbol_sequencer_if #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned PCW    = 7
) ();
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [31:0]       mem_wr_data;
  logic              start;
  logic              stop;
  logic              busy;
  logic              done;
  logic              loop_irq;
  logic [PCW-1:0]    cur_idx;

  modport master (
    output mem_wr_en, mem_wr_addr, mem_wr_data, start, stop,
    input  busy, done, loop_irq, cur_idx
  );

  modport slave (
    input  mem_wr_en, mem_wr_addr, mem_wr_data, start, stop,
    output busy, done, loop_irq, cur_idx
  );
endinterface

// File: rtl/pulse_seq_timer.sv
// Prescaled one-shot countdown. A load starts an interval of
// (duration+1) << prescaler clocks; expire is high on its last clock.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : (re)start the interval, takes priority over counting
//   prescaler  : tick every 2**prescaler clocks
//   duration   : ticks minus one
//   expire     : one-cycle pulse on the final clock of the interval
module pulse_seq_timer
  import pulse_seq_pkg::*;
#(
  parameter int unsigned DUR_W   = DEF_DUR_W,
  parameter int unsigned PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [PRESC_W-1:0] prescaler,
  input  logic [DUR_W-1:0]   duration,
  output logic               expire
);

  localparam int unsigned PRE_W = (1 << PRESC_W) - 1;

  logic [PRE_W-1:0] pre_q, pre_d, pre_reload;
  logic [PRE_W:0]   pre_pow;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic             act_q, act_d;

  always_comb begin
    pre_pow    = (PRE_W + 1)'(1) << prescaler;
    pre_reload = PRE_W'(pre_pow - (PRE_W + 1)'(1));
    expire     = act_q && (pre_q == '0) && (dur_q == '0);
    pre_d      = pre_q;
    dur_d      = dur_q;
    act_d      = act_q;
    if (load) begin
      pre_d = pre_reload;
      dur_d = duration;
      act_d = 1'b1;
    end else if (act_q) begin
      if (pre_q != '0) begin
        pre_d = pre_q - PRE_W'(1);
      end else if (dur_q != '0) begin
        dur_d = dur_q - DUR_W'(1);
        pre_d = pre_reload;
      end else begin
        act_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q <= '0;
      dur_q <= '0;
      act_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      dur_q <= dur_d;
      act_q <= act_d;
    end
  end

endmodule

// File: rtl/pulse_symbol_sequencer.sv
// Symbol-driven pulse generator: plays symbols from a word memory, each
// symbol selecting a duration from dur_table and a level from its MSB,
// with optional carrier gating and finite/infinite looping.
//   clk, rst_n   : clock, synchronous active-low reset
//   bus          : memory write port, start/stop, busy/done/loop_irq/cur_idx
//   dur_table    : flat duration table, entry s at [s*DUR_W +: DUR_W]
//   prescaler    : timer tick every 2**prescaler clocks
//   start_idx    : first symbol index, end_idx: last symbol index (inclusive)
//   loop_count   : program passes, 0 = infinite
//   carrier_en   : gate the high level with the carrier
//   carrier_half : carrier half-period minus one
//   pulse_out    : registered modulated output
module pulse_symbol_sequencer
  import pulse_seq_pkg::*;
#(
  parameter  int unsigned NUM_WORDS = DEF_NUM_WORDS,
  parameter  int unsigned SYM_BITS  = DEF_SYM_BITS,
  parameter  int unsigned DUR_W     = DEF_DUR_W,
  parameter  int unsigned PRESC_W   = DEF_PRESC_W,
  parameter  int unsigned CARRIER_W = DEF_CARRIER_W,
  localparam int unsigned PCW       = pcw_of(NUM_WORDS, SYM_BITS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  pulse_symbol_sequencer_if.slave           bus,
  input  logic [(2**SYM_BITS)*DUR_W-1:0]    dur_table,
  input  logic [PRESC_W-1:0]                prescaler,
  input  logic [PCW-1:0]                    start_idx,
  input  logic [PCW-1:0]                    end_idx,
  input  logic [7:0]                        loop_count,
  input  logic                              carrier_en,
  input  logic [CARRIER_W-1:0]              carrier_half,
  output logic                              pulse_out
);

  localparam int unsigned AW      = addr_w_of(NUM_WORDS);
  localparam int unsigned SPW_LOG = $clog2(32 / SYM_BITS);

  logic [31:0] mem_q [2**AW];

  seq_state_e           state_q;
  logic                 start_q, busy_q, done_q, irq_q, pulse_q;
  logic [PCW-1:0]       idx_q, nxt_idx;
  logic [7:0]           loops_q;
  logic [CARRIER_W-1:0] car_cnt_q, car_cnt_d;
  logic                 car_ph_q, car_ph_d;

  logic                 run, launch, expire, pass_end, finish, advance;
  logic                 timer_load, pulse_d;
  logic [SYM_BITS-1:0]  sym_cur, sym_nxt, play_sym;
  logic [DUR_W-1:0]     timer_dur;

  function automatic logic [SYM_BITS-1:0] sym_at(input logic [PCW-1:0] idx);
    logic [AW-1:0]      w;
    logic [SPW_LOG-1:0] p;
    w = AW'(idx >> SPW_LOG);
    p = SPW_LOG'(idx);
    return mem_q[w][p*SYM_BITS +: SYM_BITS];
  endfunction

  always_ff @(posedge clk) begin
    if (bus.mem_wr_en) mem_q[bus.mem_wr_addr] <= bus.mem_wr_data;
  end

  // The next symbol is fetched on the cycle its timer is loaded, so it is
  // looked up combinationally from the index that will play next.
  always_comb begin
    run        = (state_q == ST_RUN);
    launch     = !run && bus.start && !start_q && !bus.stop;
    sym_cur    = sym_at(idx_q);
    pass_end   = run && expire && (idx_q == end_idx);
    finish     = pass_end && (loops_q == 8'd1);
    advance    = run && expire && !finish;
    nxt_idx    = (launch || pass_end) ? start_idx : idx_q + PCW'(1);
    sym_nxt    = sym_at(nxt_idx);
    timer_load = launch || (advance && !bus.stop);
    timer_dur  = dur_table[sym_nxt*DUR_W +: DUR_W];
    play_sym   = (launch || advance) ? sym_nxt : sym_cur;

    car_cnt_d = car_cnt_q;
    car_ph_d  = car_ph_q;
    if (launch) begin
      car_cnt_d = carrier_half;
      car_ph_d  = 1'b0;
    end else if (run) begin
      if (car_cnt_q == '0) begin
        car_cnt_d = carrier_half;
        car_ph_d  = !car_ph_q;
      end else begin
        car_cnt_d = car_cnt_q - CARRIER_W'(1);
      end
    end
    pulse_d = play_sym[SYM_BITS-1] & (carrier_en ? car_ph_d : 1'b1);
  end

  pulse_seq_timer #(
    .DUR_W   (DUR_W),
    .PRESC_W (PRESC_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (timer_load),
    .prescaler (prescaler),
    .duration  (timer_dur),
    .expire    (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      irq_q     <= 1'b0;
      pulse_q   <= 1'b0;
      idx_q     <= '0;
      loops_q   <= '0;
      car_cnt_q <= '0;
      car_ph_q  <= 1'b0;
    end else begin
      start_q   <= bus.start;
      done_q    <= 1'b0;
      irq_q     <= 1'b0;
      car_cnt_q <= car_cnt_d;
      car_ph_q  <= car_ph_d;
      case (state_q)
        ST_IDLE: begin
          if (launch) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            idx_q   <= start_idx;
            loops_q <= loop_count;
            pulse_q <= pulse_d;
          end
        end
        ST_RUN: begin
          if (bus.stop || finish) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            pulse_q <= 1'b0;
            done_q  <= !bus.stop;
          end else begin
            pulse_q <= pulse_d;
            if (expire) idx_q <= nxt_idx;
            if (pass_end) begin
              irq_q <= 1'b1;
              // loops_q == 0 means run forever
              if (loops_q != '0) loops_q <= loops_q - 8'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pulse_out    = pulse_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.loop_irq = irq_q;
  assign bus.cur_idx  = idx_q;

endmodule

// File: tb/tb_pulse_symbol_sequencer.sv
// Directed self-checking bench for pulse_symbol_sequencer, configured with a
// single program word (PCW = 4) so index wrap-around is reachable.
module tb_pulse_symbol_sequencer;

  logic        clk;
  logic        rst_n;
  logic [31:0] dur_table;
  logic [3:0]  prescaler;
  logic [3:0]  start_idx;
  logic [3:0]  end_idx;
  logic [7:0]  loop_count;
  logic        carrier_en;
  logic [15:0] carrier_half;
  logic        pulse_out;

  int n_cmp = 0;
  int n_bad = 0;

  pulse_symbol_sequencer_if #(.ADDR_W(1), .PCW(4)) bus ();

  pulse_symbol_sequencer #(
    .NUM_WORDS (1),
    .SYM_BITS  (2),
    .DUR_W     (8),
    .PRESC_W   (4),
    .CARRIER_W (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .dur_table    (dur_table),
    .prescaler    (prescaler),
    .start_idx    (start_idx),
    .end_idx      (end_idx),
    .loop_count   (loop_count),
    .carrier_en   (carrier_en),
    .carrier_half (carrier_half),
    .pulse_out    (pulse_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [31:0] data);
    bus.mem_wr_en   = 1'b1;
    bus.mem_wr_addr = 1'b0;
    bus.mem_wr_data = data;
    @(negedge clk);
    bus.mem_wr_en   = 1'b0;
  endtask

  // Raises start; returns at the sample point of launch cycle 0.
  task automatic launch();
    bus.start = 1'b1;
    @(negedge clk);
  endtask

  task automatic release_start();
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0;
    bus.mem_wr_en = 1'b0; bus.mem_wr_addr = '0; bus.mem_wr_data = '0;
    dur_table = 32'h0002_0103;   // dur = {3,1,2,0}
    prescaler = 4'd0; start_idx = 4'd0; end_idx = 4'd3; loop_count = 8'd1;
    carrier_en = 1'b0; carrier_half = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_pulse", pulse_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_irq", bus.loop_irq, 0);
    chk("rst_idx", bus.cur_idx, 0);
    rst_n = 1'b1;
    write_word(32'h0000_00E4);

    // Single pass: low 4+2, high 3+1, done on cycle 10.
    launch();
    for (int k = 0; k <= 10; k++) begin
      chk("t1_pulse", pulse_out, (k >= 6 && k <= 9));
      chk("t1_busy", bus.busy, (k <= 9));
      chk("t1_done", bus.done, (k == 10));
      chk("t1_idx", bus.cur_idx, (k < 4) ? 0 : (k < 6) ? 1 : (k < 9) ? 2 : 3);
      @(negedge clk);
    end
    release_start();

    // Prescaler 2, three passes of 40 clocks.
    prescaler = 4'd2; loop_count = 8'd3;
    launch();
    for (int k = 0; k <= 120; k++) begin
      chk("t2_irq", bus.loop_irq, (k == 40 || k == 80));
      chk("t2_done", bus.done, (k == 120));
      if (k == 39 || k == 79) chk("t2_idx_end", bus.cur_idx, 3);
      if (k == 40 || k == 80) chk("t2_idx_wrap", bus.cur_idx, 0);
      if (k == 119 || k == 120) chk("t2_busy", bus.busy, (k == 119));
      @(negedge clk);
    end
    release_start();
    prescaler = 4'd0; loop_count = 8'd1;

    // Carrier on a single high symbol of 8 clocks.
    dur_table = 32'h0007_0103;
    carrier_en = 1'b1; carrier_half = 16'd1; start_idx = 4'd2; end_idx = 4'd2;
    launch();
    for (int k = 0; k <= 8; k++) begin
      chk("t3_carrier", pulse_out, (k < 8) ? ((k >> 1) & 1) : 0);
      chk("t3_done", bus.done, (k == 8));
      @(negedge clk);
    end
    release_start();
    start_idx = 4'd0; end_idx = 4'd0;
    launch();
    for (int k = 0; k <= 4; k++) begin
      chk("t3_low", pulse_out, 0);
      chk("t3_low_done", bus.done, (k == 4));
      @(negedge clk);
    end
    release_start();
    carrier_en = 1'b0; dur_table = 32'h0002_0103;

    // Circular program 15 -> 0 -> 1; symbol 15 is a high level.
    write_word(32'h8000_00E4);
    start_idx = 4'd15; end_idx = 4'd1;
    launch();
    for (int k = 0; k <= 9; k++) begin
      chk("t4_idx", bus.cur_idx, (k < 3) ? 15 : (k < 7) ? 0 : 1);
      chk("t4_pulse", pulse_out, (k < 3));
      chk("t4_done", bus.done, (k == 9));
      chk("t4_busy", bus.busy, (k < 9));
      @(negedge clk);
    end
    release_start();

    // Infinite loop aborted by stop during cycle 50.
    start_idx = 4'd0; end_idx = 4'd3; loop_count = 8'd0;
    launch();
    for (int k = 0; k <= 51; k++) begin
      chk("t5_irq", bus.loop_irq, (k > 0 && k <= 50 && (k % 10) == 0));
      chk("t5_done", bus.done, 0);
      chk("t5_busy", bus.busy, (k <= 50));
      chk("t5_pulse", pulse_out, (k <= 50 && (k % 10) >= 6));
      if (k == 50) bus.stop = 1'b1;
      @(negedge clk);
    end
    bus.stop = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    chk("t5_stop_wins", bus.busy, 0);
    bus.stop = 1'b0;
    @(negedge clk);
    chk("t5_no_edge", bus.busy, 0);
    release_start();
    start_idx = 4'd1;
    launch();
    chk("t5_relaunch_busy", bus.busy, 1);
    chk("t5_relaunch_idx", bus.cur_idx, 1);
    chk("t5_relaunch_pulse", pulse_out, 0);
    repeat (2) @(negedge clk);
    chk("t5_relaunch_idx2", bus.cur_idx, 2);
    chk("t5_relaunch_pulse2", pulse_out, 1);
    bus.stop = 1'b1;
    @(negedge clk);
    chk("t5_stop_again", bus.busy, 0);
    bus.stop = 1'b0;
    release_start();

    // Start edge while running is ignored; reset mid-symbol clears state.
    start_idx = 4'd2; end_idx = 4'd3;
    launch();
    chk("t6_idx0", bus.cur_idx, 2);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    chk("t6_ignored_idx", bus.cur_idx, 3);
    chk("t6_ignored_busy", bus.busy, 1);
    @(negedge clk);
    chk("t6_idx4", bus.cur_idx, 2);
    chk("t6_pulse4", pulse_out, 1);
    @(negedge clk);
    rst_n = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_pulse", pulse_out, 0);
    chk("t6_rst_idx", bus.cur_idx, 0);
    chk("t6_rst_done", bus.done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Program memory survives reset.
    start_idx = 4'd0; end_idx = 4'd3; loop_count = 8'd1;
    launch();
    chk("t6_mem_pulse0", pulse_out, 0);
    repeat (6) @(negedge clk);
    chk("t6_mem_pulse6", pulse_out, 1);
    chk("t6_mem_idx6", bus.cur_idx, 2);
    repeat (4) @(negedge clk);
    chk("t6_mem_done", bus.done, 1);
    release_start();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
